// File: rtl/vx_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_arbiter
// Purpose  : Shares one commit/writeback port among the execution units of an
//            issue slot. Packet-level round-robin with eop-based locking and a
//            single registered output stage with full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module vx_commit_arbiter #(
  parameter  int NUM_REQS = 5,
  parameter  int DATAW    = 64,
  localparam int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  input  logic [NUM_REQS-1:0]       in_eop,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_eop,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  // rr_last starts at the highest index so requester 0 wins the first scan.
  localparam logic [SEL_W-1:0] C_RR_RESET = SEL_W'(NUM_REQS - 1);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_lock_owner;
  logic [SEL_W-1:0] r_rr_last;

  logic             r_out_valid;
  logic [DATAW-1:0] r_out_data;
  logic             r_out_eop;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_stage_ready;
  logic [SEL_W-1:0] w_rr_grant;
  logic             w_rr_found;
  logic             w_owner_valid;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_valid;
  logic             w_fire;
  logic [DATAW-1:0] w_sel_data;
  logic             w_sel_eop;

  assign w_stage_ready = !r_out_valid || out_ready;

  // Round-robin scan: first valid requester after rr_last, wrapping around.
  always_comb begin
    w_rr_grant = '0;
    w_rr_found = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!w_rr_found && in_valid[(int'(r_rr_last) + 1 + k) % NUM_REQS]) begin
        w_rr_found = 1'b1;
        w_rr_grant = SEL_W'((int'(r_rr_last) + 1 + k) % NUM_REQS);
      end
    end
  end

  // Valid of the current lock owner; only this requester may proceed when locked.
  always_comb begin
    w_owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (r_lock_owner == SEL_W'(i)) begin
        w_owner_valid = in_valid[i];
      end
    end
  end

  assign w_grant       = (r_state == ST_LOCKED) ? r_lock_owner  : w_rr_grant;
  assign w_grant_valid = (r_state == ST_LOCKED) ? w_owner_valid : (|in_valid);
  // Reset blocks acceptance so no beat is consumed while the block is cleared.
  assign w_fire        = !reset && w_stage_ready && w_grant_valid;

  // Payload/eop mux for the granted requester.
  always_comb begin
    w_sel_data = '0;
    w_sel_eop  = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel_data = in_data[i*DATAW +: DATAW];
        w_sel_eop  = in_eop[i];
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_ready
      assign in_ready[i] = w_fire && (w_grant == SEL_W'(i));
    end
  endgenerate

  // Output pipe stage: load on fire, otherwise drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eop   <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_eop   <= w_sel_eop;
      r_out_sel   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Lock FSM: a non-eop beat locks onto its requester; the eop beat releases
  // it and advances the round-robin pointer, giving per-packet fairness.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_UNLOCKED;
      r_lock_owner <= '0;
      r_rr_last    <= C_RR_RESET;
    end else if (w_fire) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_sel_eop) begin
            r_rr_last <= w_grant;
          end else begin
            r_state      <= ST_LOCKED;
            r_lock_owner <= w_grant;
          end
        end
        ST_LOCKED: begin
          if (w_sel_eop) begin
            r_state   <= ST_UNLOCKED;
            r_rr_last <= r_lock_owner;
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_eop   = r_out_eop;
  assign out_sel   = r_out_sel;

`ifndef SYNTHESIS
  a_ready_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_ready));
  a_lock_owner_only : assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_LOCKED) |->
      ((in_ready & ~(NUM_REQS'(1) << r_lock_owner)) == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_commit_arbiter
// Purpose  : Directed, table-driven bench for vx_commit_arbiter (5 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_commit_arbiter;
  localparam int N  = 5;
  localparam int DW = 64;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_eop;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_eop;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  int checks   = 0;
  int failures = 0;

  vx_commit_arbiter #(.NUM_REQS(N), .DATAW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic [4:0] v;
    logic [4:0] e;
    logic       ordy;
    logic [7:0] base;
    logic [4:0] xr;
    logic       xov;
    logic [2:0] xsel;
    logic [7:0] xdata;
    logic       xeop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester i presents payload base+i.
  task automatic drive(input logic [4:0] v, input logic [4:0] e, input logic ordy,
                       input logic [7:0] base);
    in_valid  = v;
    in_eop    = e;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 64'(base) + 64'(i);
  endtask

  // One cycle: drive at negedge, check in_ready before the edge, outputs after.
  task automatic step(input string tag, input logic [4:0] v, input logic [4:0] e,
                      input logic ordy, input logic [7:0] base, input logic [4:0] xr,
                      input logic xov, input logic [2:0] xsel, input logic [7:0] xdata,
                      input logic xeop);
    @(negedge clk);
    drive(v, e, ordy, base);
    #1;
    check($sformatf("%s in_ready", tag), 64'(in_ready), 64'(xr));
    @(posedge clk);
    #1;
    check($sformatf("%s out_valid", tag), 64'(out_valid), 64'(xov));
    if (xov) begin
      check($sformatf("%s out_sel", tag), 64'(out_sel), 64'(xsel));
      check($sformatf("%s out_data", tag), out_data, 64'(xdata));
      check($sformatf("%s out_eop", tag), 64'(out_eop), 64'(xeop));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(5'b11111, 5'b11111, 1'b1, 8'h00);
    #1;
    check("rst in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    drive(5'b00000, 5'b00000, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("rst out_valid2", 64'(out_valid), 64'h0);
    check("rst out_sel", 64'(out_sel), 64'h0);
    check("rst out_data", out_data, 64'h0);
    check("rst out_eop", 64'(out_eop), 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic rb, input logic [4:0] v, input logic [4:0] e,
                     input logic ordy, input logic [7:0] base, input logic [4:0] xr,
                     input logic xov, input logic [2:0] xsel, input logic [7:0] xdata,
                     input logic xeop);
    vec_t t;
    t.rst_before = rb; t.v = v; t.e = e; t.ordy = ordy; t.base = base;
    t.xr = xr; t.xov = xov; t.xsel = xsel; t.xdata = xdata; t.xeop = xeop;
    vecs.push_back(t);
  endtask

  initial begin
    drive(5'b00000, 5'b00000, 1'b1, 8'h00);

    // Round robin, all valid single-beat: 0,1,2,3,4,0,1
    add(1, 5'b11111, 5'b11111, 1, 8'h10, 5'b00001, 1, 0, 8'h10, 1);
    add(0, 5'b11111, 5'b11111, 1, 8'h20, 5'b00010, 1, 1, 8'h21, 1);
    add(0, 5'b11111, 5'b11111, 1, 8'h30, 5'b00100, 1, 2, 8'h32, 1);
    add(0, 5'b11111, 5'b11111, 1, 8'h40, 5'b01000, 1, 3, 8'h43, 1);
    add(0, 5'b11111, 5'b11111, 1, 8'h50, 5'b10000, 1, 4, 8'h54, 1);
    add(0, 5'b11111, 5'b11111, 1, 8'h60, 5'b00001, 1, 0, 8'h60, 1);
    add(0, 5'b11111, 5'b11111, 1, 8'h70, 5'b00010, 1, 1, 8'h71, 1);
    // 3-beat packet on req1 with req0/req3 waiting: 1,1,1,3,0
    add(1, 5'b00010, 5'b00000, 1, 8'hA0, 5'b00010, 1, 1, 8'hA1, 0);
    add(0, 5'b01011, 5'b01001, 1, 8'hB0, 5'b00010, 1, 1, 8'hB1, 0);
    add(0, 5'b01011, 5'b01011, 1, 8'hC0, 5'b00010, 1, 1, 8'hC1, 1);
    add(0, 5'b01001, 5'b01001, 1, 8'hD0, 5'b01000, 1, 3, 8'hD3, 1);
    add(0, 5'b00001, 5'b00001, 1, 8'hE0, 5'b00001, 1, 0, 8'hE0, 1);
    // Locked owner goes idle: two bubbles, req0 stalled, then owner finishes
    add(1, 5'b00010, 5'b00000, 1, 8'h10, 5'b00010, 1, 1, 8'h11, 0);
    add(0, 5'b00001, 5'b00001, 1, 8'h20, 5'b00000, 0, 0, 8'h00, 0);
    add(0, 5'b00001, 5'b00001, 1, 8'h30, 5'b00000, 0, 0, 8'h00, 0);
    add(0, 5'b00011, 5'b00011, 1, 8'h40, 5'b00010, 1, 1, 8'h41, 1);
    add(0, 5'b00001, 5'b00001, 1, 8'h50, 5'b00001, 1, 0, 8'h50, 1);
    // Back-pressure for 4 cycles, then drain and reload in the same cycle
    add(1, 5'b00001, 5'b00001, 1, 8'h10, 5'b00001, 1, 0, 8'h10, 1);
    add(0, 5'b00110, 5'b00110, 0, 8'h20, 5'b00000, 1, 0, 8'h10, 1);
    add(0, 5'b00110, 5'b00110, 0, 8'h20, 5'b00000, 1, 0, 8'h10, 1);
    add(0, 5'b00110, 5'b00110, 0, 8'h20, 5'b00000, 1, 0, 8'h10, 1);
    add(0, 5'b00110, 5'b00110, 0, 8'h20, 5'b00000, 1, 0, 8'h10, 1);
    add(0, 5'b00110, 5'b00110, 1, 8'h20, 5'b00010, 1, 1, 8'h21, 1);
    add(0, 5'b00100, 5'b00100, 1, 8'h30, 5'b00100, 1, 2, 8'h32, 1);
    add(0, 5'b00000, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 8'h00, 0);

    // Reset release with idle inputs, then a single beat from req2
    do_reset();
    for (int c = 0; c < 10; c++)
      step("idle", 5'b00000, 5'b00000, 1, 8'h00, 5'b00000, 0, 0, 8'h00, 0);
    step("first", 5'b00100, 5'b00100, 1, 8'hA9, 5'b00100, 1, 2, 8'hAB, 1);

    // Table-driven scenarios
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst_before) do_reset();
      step($sformatf("vec%0d", k), vecs[k].v, vecs[k].e, vecs[k].ordy, vecs[k].base,
           vecs[k].xr, vecs[k].xov, vecs[k].xsel, vecs[k].xdata, vecs[k].xeop);
    end

    // Reset in the middle of a packet locked on req2
    do_reset();
    step("lk0", 5'b00100, 5'b00000, 1, 8'h10, 5'b00100, 1, 2, 8'h12, 0);
    step("lk1", 5'b11111, 5'b00000, 1, 8'h20, 5'b00100, 1, 2, 8'h22, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    check("midrst out_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    step("postrst", 5'b11111, 5'b11111, 1, 8'h30, 5'b00001, 1, 0, 8'h30, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
